// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle byte-fetch MIPS-subset datapath.
// One state per cycle: four byte fetches, a decode, then a short execute tail.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       pcen,
    output logic       pcsource,
    output logic       irenable,
    output logic [3:0] irwrite,
    output logic       lord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucont,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH1  = 4'd0;
    localparam logic [3:0] FETCH2  = 4'd1;
    localparam logic [3:0] FETCH3  = 4'd2;
    localparam logic [3:0] FETCH4  = 4'd3;
    localparam logic [3:0] DECODE  = 4'd4;
    localparam logic [3:0] MEMADR  = 4'd5;
    localparam logic [3:0] LBRD    = 4'd6;
    localparam logic [3:0] LBWR    = 4'd7;
    localparam logic [3:0] SBWR    = 4'd8;
    localparam logic [3:0] RTYPEEX = 4'd9;
    localparam logic [3:0] RTYPEWR = 4'd10;
    localparam logic [3:0] BEQEX   = 4'd11;
    localparam logic [3:0] BEQ2    = 4'd12;
    localparam logic [3:0] JEX     = 4'd13;
    localparam logic [3:0] ADDIEX  = 4'd14;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] next_state;

    function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
        case (f)
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH1;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH1;
        case (state)
            FETCH1:  next_state = FETCH2;
            FETCH2:  next_state = FETCH3;
            FETCH3:  next_state = FETCH4;
            FETCH4:  next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_J:         next_state = JEX;
                    OP_ADDI:      next_state = ADDIEX;
                    default:      next_state = FETCH1;
                endcase
            end
            MEMADR:  next_state = (op == OP_LB) ? LBRD : SBWR;
            LBRD:    next_state = LBWR;
            RTYPEEX: next_state = RTYPEWR;
            BEQEX:   next_state = BEQ2;
            default: next_state = FETCH1;
        endcase
    end

    // NOTE: every output gets a default first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        pcen     = 1'b0;
        pcsource = 1'b0;
        irenable = 1'b0;
        irwrite  = 4'b0000;
        lord     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        alucont  = ALU_ADD;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        illegal  = 1'b0;
        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread  = 1'b1;
                irenable = 1'b1;
                irwrite  = 4'b0001 << state[1:0];
                alusrcb  = 2'b01;
                pcen     = 1'b1;
            end
            DECODE: begin
                illegal = !(op inside {OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI});
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                memread = 1'b1;
                iord    = 1'b1;
                lord    = 1'b1;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                alucont = alu_from_funct(funct);
            end
            RTYPEWR: begin
                alusrca  = 1'b1;
                alucont  = alu_from_funct(funct);
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            ADDIEX: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                alucont = ALU_SUB;
            end
            BEQ2: begin
                alusrcb = 2'b11;
                pcen    = zero;
            end
            JEX: begin
                pcsource = 1'b1;
                pcen     = 1'b1;
            end
            default: ;
        endcase

        // State already sits at FETCH1 under reset; only the side-effecting strobes need masking.
        if (reset) begin
            pcen     = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            irenable = 1'b0;
            irwrite  = 4'b0000;
            lord     = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction behavioural
// model with randomized opcodes/functs/zero plus directed scenario checks.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       memread, memwrite, iord, pcen, pcsource, irenable;
        logic [3:0] irwrite;
        logic       lord, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucont;
        logic       regwrite, regdst, memtoreg, illegal;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       memread, memwrite, iord, pcen, pcsource, irenable, lord;
    logic       alusrca, regwrite, regdst, memtoreg, illegal;
    logic [3:0] irwrite, state;
    logic [1:0] alusrcb;
    logic [2:0] alucont;

    outs_t dut_outs, exp_outs;
    outs_t act_q[$];
    string exp_tag;
    logic  check_en = 1'b0;
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memread(memread), .memwrite(memwrite), .iord(iord), .pcen(pcen),
        .pcsource(pcsource), .irenable(irenable), .irwrite(irwrite), .lord(lord),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucont(alucont),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .illegal(illegal), .state(state)
    );

    assign dut_outs = {state, memread, memwrite, iord, pcen, pcsource, irenable,
                       irwrite, lord, alusrca, alusrcb, alucont,
                       regwrite, regdst, memtoreg, illegal};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycles from FETCH1 back to FETCH1 for each instruction class.
    function automatic int latency(input logic [5:0] o);
        case (o)
            6'b100000: return 8;
            6'b101000: return 7;
            6'b000000: return 7;
            6'b001000: return 6;
            6'b000100: return 7;
            6'b000010: return 6;
            default:   return 5;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for cycle 'step' of an instruction, described per instruction class.
    function automatic outs_t model(input logic [5:0] o, input logic [5:0] f,
                                    input int step, input logic z);
        outs_t e;
        e = '0;
        e.alucont = 3'b010;
        if (step < 4) begin
            e.state    = 4'(step);
            e.memread  = 1'b1;
            e.irenable = 1'b1;
            e.irwrite  = 4'(1 << step);
            e.alusrcb  = 2'b01;
            e.pcen     = 1'b1;
        end else if (step == 4) begin
            e.state   = 4'd4;
            e.illegal = (latency(o) == 5);
        end else begin
            case (o)
                6'b100000: begin
                    e.state = (step == 5) ? 4'd5 : (step == 6) ? 4'd6 : 4'd7;
                    if (step < 7) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                    if (step == 6) begin e.memread = 1'b1; e.iord = 1'b1; e.lord = 1'b1; end
                    if (step == 7) begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
                end
                6'b101000: begin
                    e.state   = (step == 5) ? 4'd5 : 4'd8;
                    e.alusrca = 1'b1;
                    e.alusrcb = 2'b10;
                    if (step == 6) begin e.memwrite = 1'b1; e.iord = 1'b1; end
                end
                6'b000000: begin
                    e.state    = (step == 5) ? 4'd9 : 4'd10;
                    e.alusrca  = 1'b1;
                    e.alucont  = alu_of(f);
                    e.regwrite = (step == 6);
                    e.regdst   = (step == 6);
                end
                6'b001000: begin
                    e.state    = 4'd14;
                    e.alusrca  = 1'b1;
                    e.alusrcb  = 2'b10;
                    e.regwrite = 1'b1;
                end
                6'b000100: begin
                    if (step == 5) begin
                        e.state = 4'd11; e.alusrca = 1'b1; e.alucont = 3'b110;
                    end else begin
                        e.state = 4'd12; e.alusrcb = 2'b11; e.pcen = z;
                    end
                end
                6'b000010: begin
                    e.state = 4'd13; e.pcsource = 1'b1; e.pcen = 1'b1;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Outputs while reset is held: FETCH1 values with all strobes masked.
    function automatic outs_t reset_outs();
        outs_t e;
        e = '0;
        e.alusrcb = 2'b01;
        e.alucont = 3'b010;
        return e;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            check(exp_tag, 32'(dut_outs), 32'(exp_outs));
            act_q.push_back(dut_outs);
        end
    end

    // zmode: 0 = zero low, 1 = zero high, 2 = random each cycle. Stops early after stop_at cycles.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input int stop_at);
        op    = o;
        funct = f;
        for (int s = 0; s < latency(o) && s < stop_at; s++) begin
            zero     = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            exp_outs = model(o, f, s, zero);
            exp_tag  = $sformatf("op=%b funct=%b step=%0d", o, f, s);
            check_en = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cnt;
        logic [5:0] rop, rfn;
        reset = 1'b0;
        op    = 6'b0;
        funct = 6'b0;
        zero  = 1'b0;

        // Asynchronous reset takes effect before the first clock edge.
        #2 reset = 1'b1;
        #1 check("reset_async_state", 32'(state), 32'd0);
        check("reset_outs", 32'(dut_outs), 32'(reset_outs()));
        repeat (2) @(posedge clk);
        #1 check("reset_held_outs", 32'(dut_outs), 32'(reset_outs()));
        reset = 1'b0;

        // R-type sub: state trace, ALU op and write-back placement.
        act_q.delete();
        run_instr(6'b000000, 6'b100010, 0, 99);
        check("rsub_len", 32'(act_q.size()), 32'd7);
        check("rsub_trace", {act_q[0].state, act_q[1].state, act_q[2].state, act_q[3].state,
                             act_q[4].state, act_q[5].state, act_q[6].state, 4'd0},
              32'h0123_49A0);
        check("rsub_return", 32'(state), 32'd0);
        check("rsub_alu", {act_q[5].alucont, act_q[6].alucont}, 6'b110_110);
        cnt = 0;
        foreach (act_q[i]) if (act_q[i].regwrite) cnt++;
        check("rsub_regwrite_cnt", 32'(cnt), 32'd1);
        check("rsub_wr_regdst", {act_q[6].regwrite, act_q[6].regdst}, 2'b11);

        // FETCH byte-lane walk and PC increments.
        check("ir_lanes", {act_q[0].irwrite, act_q[1].irwrite, act_q[2].irwrite, act_q[3].irwrite},
              16'h1248);
        check("ir_pcen", {act_q[0].pcen, act_q[1].pcen, act_q[2].pcen, act_q[3].pcen}, 4'hF);

        // lb: memory read path.
        act_q.delete();
        run_instr(6'b100000, 6'b0, 0, 99);
        check("lb_rd", {act_q[6].state, act_q[6].iord, act_q[6].lord}, 6'b0110_11);
        check("lb_wr", {act_q[7].state, act_q[7].regwrite, act_q[7].memtoreg}, 6'b0111_11);
        cnt = 0;
        foreach (act_q[i]) if (act_q[i].memread) cnt++;
        check("lb_memread_cnt", 32'(cnt), 32'd5);

        // beq taken then not taken.
        act_q.delete();
        run_instr(6'b000100, 6'b0, 1, 99);
        check("beq_taken", {act_q[6].state, act_q[6].pcen, act_q[6].alusrcb}, 7'b1100_1_11);
        act_q.delete();
        run_instr(6'b000100, 6'b0, 0, 99);
        check("beq_not_taken", {act_q[6].state, act_q[6].pcen}, 5'b1100_0);

        // Undecodable opcode.
        act_q.delete();
        run_instr(6'b111111, 6'b0, 0, 99);
        cnt = 0;
        foreach (act_q[i]) if (act_q[i].illegal) cnt++;
        check("illegal_cnt", 32'(cnt), 32'd1);
        check("illegal_at_decode", {act_q[4].state, act_q[4].illegal}, 5'b0100_1);
        cnt = 0;
        foreach (act_q[i]) if (act_q[i].regwrite || act_q[i].memwrite) cnt++;
        check("illegal_no_side_effect", 32'(cnt), 32'd0);
        check("illegal_return", 32'(state), 32'd0);

        // Randomized instruction stream against the model.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: rop = 6'b100000;
                1: rop = 6'b101000;
                2: rop = 6'b000000;
                3: rop = 6'b000000;
                4: rop = 6'b000100;
                5: rop = 6'b000010;
                6: rop = 6'b001000;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 5))
                0: rfn = 6'b100000;
                1: rfn = 6'b100010;
                2: rfn = 6'b100100;
                3: rfn = 6'b100101;
                4: rfn = 6'b101010;
                default: rfn = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, rfn, 2, 99);
        end

        // Reset asserted mid-cycle while in SBWR.
        run_instr(6'b101000, 6'b0, 0, 6);
        check_en = 1'b0;
        check("sbwr_before_reset", {state, memwrite}, 5'b1000_1);
        #2 reset = 1'b1;
        #1 check("sbwr_reset_memwrite", 32'(memwrite), 32'd0);
        check("sbwr_reset_state", 32'(state), 32'd0);
        check("sbwr_reset_outs", 32'(dut_outs), 32'(reset_outs()));
        @(posedge clk);
        #1 check("sbwr_reset_held", 32'(dut_outs), 32'(reset_outs()));
        reset = 1'b0;

        // Recovery after reset: full instructions run normally again.
        run_instr(6'b001000, 6'b0, 0, 99);
        run_instr(6'b000010, 6'b0, 0, 99);
        check_en = 1'b0;
        check("final_state", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports clk, input, 1, the single rising-edge clock; and reset, input, 1, asynchronous active-high reset.
REQ-002 SHALL have ports op, input, 6, opcode instr[31:26]; and funct, input, 6, instr[5:0].
REQ-003 SHALL have port zero, input, 1, registered ALU-zero flag from the datapath, updated every cycle.
REQ-004 SHALL have ports memread, output, 1, memory read strobe; memwrite, output, 1, memory write strobe; and iord, output, 1, memory address select (0 = pc, 1 = aluout).
REQ-005 SHALL have ports pcen, output, 1, PC load enable; and pcsource, output, 1, next-PC select (0 = aluout, 1 = jumpaddr).
REQ-006 SHALL have ports irenable, output, 1, instruction register enable; irwrite, output, 4, one-hot byte lane of the IR to load; and lord, output, 1, memdata register load.
REQ-007 SHALL have ports alusrca, output, 1, ALU A select (0 = pc, 1 = rd1); alusrcb, output, 2, ALU B select (00 = rd2, 01 = 1, 10 = imm, 11 = imm<<2); and alucont, output, 3, ALU operation.
REQ-008 SHALL have ports regwrite, output, 1, register write; regdst, output, 1, write register select (0 = rt, 1 = rd); and memtoreg, output, 1, write data select (0 = aluout, 1 = memdata).
REQ-009 SHALL have ports illegal, output, 1, one-cycle pulse on an undecodable opcode; and state, output, 4, current state code for debug.

Function
REQ-010 SHALL implement a Moore FSM with states and codes FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, BEQ2=12, JEX=13, ADDIEX=14.
REQ-011 SHALL encode alucont as add=010, sub=110, and=000, or=001, slt=111.
REQ-012 SHALL drive every output not listed for a state to 0, except alucont, which defaults to add.
REQ-013 SHALL, in FETCHn (n = 1..4), assert memread and irenable, set irwrite = 1<<(n-1), set alusrca=0, alusrcb=01, alucont=add, pcsource=0, pcen=1, and advance to FETCH(n+1), with FETCH4 advancing to DECODE.
REQ-014 SHALL, in DECODE, assert no enables and branch on op: 100000 (lb) or 101000 (sb) to MEMADR, 000000 (R-type) to RTYPEEX, 000100 (beq) to BEQEX, 000010 (j) to JEX, 001000 (addi) to ADDIEX, and any other op to FETCH1 with illegal=1 for that cycle.
REQ-015 SHALL, in MEMADR, set alusrca=1, alusrcb=10, alucont=add, then go to LBRD if op=100000, otherwise to SBWR.
REQ-016 SHALL, in LBRD, hold the MEMADR ALU settings, assert memread, iord and lord, and go to LBWR.
REQ-017 SHALL, in LBWR, assert regwrite and memtoreg with regdst=0, and go to FETCH1.
REQ-018 SHALL, in SBWR, hold the MEMADR ALU settings, assert memwrite and iord, and go to FETCH1.
REQ-019 SHALL, in RTYPEEX, set alusrca=1, alusrcb=00, and alucont from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, any other value add), then go to RTYPEWR.
REQ-020 SHALL, in RTYPEWR, hold the RTYPEEX ALU settings, assert regwrite with regdst=1 and memtoreg=0, and go to FETCH1.
REQ-021 SHALL, in ADDIEX, set alusrca=1, alusrcb=10, alucont=add, assert regwrite with regdst=0 and memtoreg=0, and go to FETCH1.
REQ-022 SHALL, in BEQEX, set alusrca=1, alusrcb=00, alucont=sub, and go to BEQ2.
REQ-023 SHALL, in BEQ2, set alusrca=0, alusrcb=11, alucont=add, pcsource=0, drive pcen=zero as the only combinational input dependency, and go to FETCH1.
REQ-024 SHALL, in JEX, set pcsource=1 and pcen=1, and go to FETCH1.
REQ-025 SHALL keep irwrite one-hot or zero, and assert irenable only in FETCH1-FETCH4.
REQ-026 SHALL never assert memread and memwrite in the same cycle.
REQ-027 SHALL use the following instruction latencies in cycles, FETCH1 through the return to FETCH1: lb 8, sb 7, R-type 7, addi 6, beq 7, j 6, illegal 5.

Reset
REQ-028 SHALL, on reset assertion, immediately force state to FETCH1 without waiting for a clock edge.
REQ-029 SHALL, while reset is high, force pcen, memread, memwrite, irenable, irwrite, lord, regwrite and illegal to 0, and leave the other outputs at their FETCH1 values.
REQ-030 SHALL, on the first rising clk edge after reset deasserts, be in FETCH1 with its outputs live.
REQ-031 SHALL, on reset asserted mid-instruction (any state), abort that instruction with no further regwrite or memwrite.

Verification
REQ-032 SHALL cover reset release followed by op=000000, funct=100010: states 0,1,2,3,4,9,10,0; alucont=110 in states 9 and 10; regwrite=1 and regdst=1 only in state 10.
REQ-033 SHALL cover op=100000 (lb): iord=1 and lord=1 in state 6; regwrite=1 and memtoreg=1 in state 7; memread=1 in 5 of the 8 cycles.
REQ-034 SHALL cover op=000100 (beq) with zero=1 in BEQ2: pcen=1 and alusrcb=11; repeat with zero=0: pcen=0.
REQ-035 SHALL cover op=111111: illegal=1 for exactly one cycle in DECODE, then FETCH1, with no regwrite or memwrite asserted.
REQ-036 SHALL cover reset asserted asynchronously mid-cycle in SBWR: memwrite drops to 0 before the next edge, and state=0.
REQ-037 SHALL cover an irwrite sequence over FETCH1-FETCH4 of 0001, 0010, 0100, 1000 with pcen=1 in each of those cycles.
